// File: rtl/xmint_pkg.sv
// Shared types and constants for the xmint fetch front end.
// Fetch-enable key, FIFO entry layout and prefetch FSM states.
package xmint_pkg;

  localparam logic [3:0] FETCH_EN_ON = 4'b0101;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_RUN,
    PF_HALT_ERR
  } pf_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/xmint_fifo.sv
// Generic synchronous FIFO with flush, count and full/empty.
// Push while full is accepted when a pop happens in the same cycle.
module xmint_fifo #(
  parameter int DEPTH = 4,
  parameter type entry_t = logic [31:0],
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  entry_t        wdata_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output entry_t        rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty_o = count_o == '0;
  assign full_o  = count_o == CW'(DEPTH);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (do_push & ~flush_i) mem[wptr] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr    <= '0;
      rptr    <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      wptr    <= '0;
      rptr    <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      count_o <= count_o + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/xmint_prefetch_buffer.sv
// xmint instruction prefetch buffer: req/gnt/rvalid fetch engine
// with response FIFO toward decode and redirect-driven discard.
module xmint_prefetch_buffer
  import xmint_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] boot_addr_i,
  input  logic [3:0]  fetch_enable_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        fetch_err_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] MAX_W = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  pf_state_e     state;
  logic [31:0]   req_addr;
  logic [31:0]   rsp_addr;
  logic [31:0]   hold_addr;
  logic          req_hold;
  logic          hold_stale;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] out_next;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   fill;
  logic          fifo_full;
  logic          fifo_empty;
  logic          en;
  logic          issue;
  logic          gnt_fire;
  logic          stale_gnt;
  logic          redirect;
  logic          accept;
  logic          drop_rsp;
  logic          pop;
  fetch_entry_t  wdata;
  fetch_entry_t  head;

  assign en   = fetch_enable_i == FETCH_EN_ON;
  assign fill = {1'b0, fifo_count} + {1'b0, outstanding};

  // Reserving a FIFO slot per in-flight request makes overflow impossible.
  assign issue = (state == PF_RUN) & en & ~fifo_full
               & (outstanding < MAX_W) & (fill < DEPTH_W);

  assign instr_req_o  = req_hold | issue;
  assign instr_addr_o = req_hold ? hold_addr : req_addr;

  assign gnt_fire  = instr_req_o & instr_gnt_i;
  assign stale_gnt = gnt_fire & req_hold & hold_stale;
  assign redirect  = branch_i & (state != PF_IDLE);
  assign drop_rsp  = instr_rvalid_i & (discard != '0);
  assign accept    = instr_rvalid_i & (discard == '0) & ~redirect;
  assign pop       = fetch_valid_o & fetch_ready_i & ~redirect;
  assign out_next  = outstanding + CW'(gnt_fire) - CW'(instr_rvalid_i);

  assign wdata = '{rdata: instr_rdata_i, addr: rsp_addr, err: instr_err_i};

  xmint_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .wdata_i (wdata),
    .pop_i   (pop),
    .flush_i (redirect),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign fetch_valid_o = ~fifo_empty;
  assign fetch_rdata_o = fetch_valid_o ? head.rdata : '0;
  assign fetch_addr_o  = fetch_valid_o ? head.addr : '0;
  assign fetch_err_o   = fetch_valid_o & head.err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= PF_IDLE;
      req_addr    <= '0;
      rsp_addr    <= '0;
      hold_addr   <= '0;
      req_hold    <= 1'b0;
      hold_stale  <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_next;

      if (redirect) discard <= out_next;
      else discard <= discard + CW'(stale_gnt) - CW'(drop_rsp);

      // An ungranted request is frozen; a redirect marks it stale.
      if (gnt_fire) begin
        req_hold   <= 1'b0;
        hold_stale <= 1'b0;
      end else if (instr_req_o) begin
        req_hold  <= 1'b1;
        hold_addr <= instr_addr_o;
        if (redirect) hold_stale <= 1'b1;
      end

      unique case (state)
        PF_IDLE: begin
          if (en) begin
            state    <= PF_RUN;
            req_addr <= word_align(boot_addr_i);
            rsp_addr <= word_align(boot_addr_i);
          end
        end
        PF_RUN, PF_HALT_ERR: begin
          if (redirect) begin
            state    <= PF_RUN;
            req_addr <= word_align(branch_addr_i);
            rsp_addr <= word_align(branch_addr_i);
          end else begin
            if (gnt_fire & ~hold_stale) req_addr <= req_addr + 32'd4;
            if (accept) begin
              rsp_addr <= rsp_addr + 32'd4;
              if (instr_err_i) state <= PF_HALT_ERR;
            end
          end
        end
        default: state <= PF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xmint_prefetch_buffer.sv
// Directed bench for xmint_prefetch_buffer with an in-order memory
// responder and an expected-entry scoreboard on the decode side.
module tb_xmint_prefetch_buffer;
  import xmint_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] boot_addr = 32'h80;
  logic [3:0]  fetch_en = 4'b0000;
  logic        req;
  logic        gnt = 1'b0;
  logic [31:0] addr;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        rerr = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        fvalid;
  logic        fready = 1'b0;
  logic [31:0] frdata;
  logic [31:0] faddr;
  logic        ferr;

  always #5 clk = ~clk;

  xmint_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .boot_addr_i    (boot_addr),
    .fetch_enable_i (fetch_en),
    .instr_req_o    (req),
    .instr_gnt_i    (gnt),
    .instr_addr_o   (addr),
    .instr_rvalid_i (rvalid),
    .instr_rdata_i  (rdata),
    .instr_err_i    (rerr),
    .branch_i       (branch),
    .branch_addr_i  (branch_addr),
    .fetch_valid_o  (fvalid),
    .fetch_ready_i  (fready),
    .fetch_rdata_o  (frdata),
    .fetch_addr_o   (faddr),
    .fetch_err_o    (ferr)
  );

  typedef struct {
    logic [31:0] a;
    bit          drop;
  } pend_t;

  fetch_entry_t exp_q[$];
  pend_t        pend[$];
  pend_t        p;
  fetch_entry_t e;
  int           n_chk = 0;
  int           n_fail = 0;
  int           grants = 0;
  int           mdl_out = 0;
  int           occ = 0;
  int           g0;
  bit           prev_push = 0;
  bit           rsp_stall = 0;
  int           drop_grants = 0;
  logic [31:0]  drop_addr = '0;
  logic [31:0]  exp_req_addr = '0;
  logic [31:0]  err_addr = 32'h2;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_branch(input logic [31:0] a);
    branch = 1'b1;
    branch_addr = a;
    tick();
    branch = 1'b0;
  endtask

  task automatic drain(input string tag);
    fetch_en = 4'b0000;
    tick(8);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Decode-side scoreboard plus in-order memory model.
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      exp_q.delete();
      mdl_out = 0;
      occ = 0;
      prev_push = 0;
      rvalid = 1'b0;
      rdata = '0;
      rerr = 1'b0;
    end else begin
      if (prev_push) check("latency", 32'(fvalid), 32'd1);
      if (fvalid && fready && !branch) begin
        if (exp_q.size() == 0) begin
          check("spurious_pop", 32'(fvalid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pop_addr", faddr, e.addr);
          check("pop_rdata", frdata, e.rdata);
          check("pop_err", 32'(ferr), 32'(e.err));
          occ--;
        end
      end
      prev_push = 0;
      if (!rsp_stall && pend.size() > 0) begin
        p = pend.pop_front();
        rvalid = 1'b1;
        rdata = mem_word(p.a);
        rerr = (p.a == err_addr);
        mdl_out--;
        if (!p.drop) begin
          occ++;
          prev_push = 1;
          check("fifo_bound", 32'(occ <= DEPTH), 32'd1);
        end
      end else begin
        rvalid = 1'b0;
        rdata = '0;
        rerr = 1'b0;
      end
      if (req && gnt) begin
        grants++;
        mdl_out++;
        check("max_outstanding", 32'(mdl_out <= MAXO), 32'd1);
        if (drop_grants > 0) begin
          check("drop_req_addr", addr, drop_addr);
          pend.push_back('{a: drop_addr, drop: 1'b1});
          drop_addr += 32'd4;
          drop_grants--;
        end else begin
          check("req_addr", addr, exp_req_addr);
          exp_q.push_back('{rdata: mem_word(exp_req_addr),
                            addr: exp_req_addr,
                            err: exp_req_addr == err_addr});
          pend.push_back('{a: exp_req_addr, drop: 1'b0});
          exp_req_addr += 32'd4;
        end
      end
    end
  end

  initial begin
    #1;
    check("rst_req", 32'(req), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_fvalid", 32'(fvalid), 32'd0);
    check("rst_frdata", frdata, 32'd0);
    check("rst_faddr", faddr, 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    tick(2);
    rst = 1'b0;
    do_branch(32'h999);
    tick();
    check("idle_no_req", 32'(req), 32'd0);

    // Boot fetch stream with 1-cycle responses
    exp_req_addr = 32'h80;
    fready = 1'b1;
    gnt = 1'b1;
    fetch_en = FETCH_EN_ON;
    g0 = grants;
    tick();
    check("first_req", 32'(req), 32'd1);
    check("first_addr", addr, 32'h80);
    tick(11);
    check("t1_grants", 32'(grants >= g0 + 3), 32'd1);
    drain("t1_drain");

    // Backpressure: FIFO fills, then resumes
    fready = 1'b0;
    fetch_en = FETCH_EN_ON;
    g0 = grants;
    tick(10);
    check("t2_grants", 32'(grants - g0), 32'd4);
    check("t2_req_off", 32'(req), 32'd0);
    check("t2_valid", 32'(fvalid), 32'd1);
    fready = 1'b1;
    tick(6);
    drain("t2_drain");

    // Branch with two responses in flight
    do_branch(32'h100);
    drop_grants = 2;
    drop_addr = 32'h100;
    exp_req_addr = 32'h200;
    rsp_stall = 1;
    g0 = grants;
    fetch_en = FETCH_EN_ON;
    tick(4);
    check("t3_grants", 32'(grants - g0), 32'd2);
    check("t3_req_off", 32'(req), 32'd0);
    do_branch(32'h200);
    rsp_stall = 0;
    check("t3_novalid0", 32'(fvalid), 32'd0);
    tick();
    check("t3_novalid1", 32'(fvalid), 32'd0);
    tick();
    check("t3_novalid2", 32'(fvalid), 32'd0);
    tick(4);
    drain("t3_drain");

    // Branch while a request waits for grant
    gnt = 1'b0;
    do_branch(32'h10);
    drop_grants = 1;
    drop_addr = 32'h10;
    exp_req_addr = 32'h40;
    fetch_en = FETCH_EN_ON;
    tick(3);
    check("t4_req", 32'(req), 32'd1);
    check("t4_addr", addr, 32'h10);
    do_branch(32'h40);
    check("t4_hold_req", 32'(req), 32'd1);
    check("t4_hold_addr", addr, 32'h10);
    tick();
    check("t4_hold_addr2", addr, 32'h10);
    gnt = 1'b1;
    g0 = grants;
    tick(5);
    check("t4_grants", 32'(grants - g0 >= 2), 32'd1);
    drain("t4_drain");

    // Bus error halts fetch until a branch
    err_addr = 32'h20;
    exp_req_addr = 32'h20;
    do_branch(32'h20);
    g0 = grants;
    fetch_en = FETCH_EN_ON;
    tick(6);
    check("t5_grants", 32'(grants - g0), 32'd2);
    check("t5_halt_req", 32'(req), 32'd0);
    err_addr = 32'h2;
    exp_req_addr = 32'h300;
    do_branch(32'h300);
    check("t5_restart_req", 32'(req), 32'd1);
    check("t5_restart_addr", addr, 32'h300);
    tick(4);
    drain("t5_drain");

    // Address wrap past 0xFFFFFFFC, unaligned target
    exp_req_addr = 32'hFFFF_FFF8;
    do_branch(32'hFFFF_FFFB);
    fetch_en = FETCH_EN_ON;
    tick(6);
    drain("t7_drain");

    // Reset mid-run with two outstanding
    do_branch(32'h400);
    drop_grants = 2;
    drop_addr = 32'h400;
    rsp_stall = 1;
    fetch_en = FETCH_EN_ON;
    tick(4);
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(req), 32'd0);
    check("mid_rst_addr", addr, 32'd0);
    check("mid_rst_fvalid", 32'(fvalid), 32'd0);
    check("mid_rst_faddr", faddr, 32'd0);
    drop_grants = 0;
    rsp_stall = 0;
    boot_addr = 32'h503;
    exp_req_addr = 32'h500;
    tick(2);
    rst = 1'b0;
    tick();
    check("t6_req", 32'(req), 32'd1);
    check("t6_addr", addr, 32'h500);
    tick(4);
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xmint_prefetch_buffer.md
Name: xmint_prefetch_buffer

Overview:
- Instruction-fetch front end for the xmint core. Issues word-aligned fetches over the core's req/gnt/rvalid instruction-memory interface.
- Supports up to MAX_OUTSTANDING in-flight requests and buffers responses in a DEPTH-entry FIFO toward decode.
- Handles branch redirects by flushing the FIFO and discarding stale in-flight responses. Gated by fetch_enable_i.
- Sits between xmint_top's instr_* ports and the decode stage, replacing the tied-off instruction interface.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- MAX_OUTSTANDING, 2, max granted-but-unanswered requests; 1..DEPTH.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- boot_addr_i  in  32  first fetch address after enable; bits [1:0] ignored
- fetch_enable_i  in  4  fetching allowed only when == FETCH_EN_ON (4'b0101)
- instr_req_o  out  1  request valid
- instr_gnt_i  in  1  request accepted
- instr_addr_o  out  32  word address; [1:0] always 0
- instr_rvalid_i  in  1  response valid; responses arrive in order
- instr_rdata_i  in  32  response data
- instr_err_i  in  1  response bus error, valid with rvalid
- branch_i  in  1  redirect request
- branch_addr_i  in  32  redirect target; bits [1:0] ignored
- fetch_valid_o  out  1  FIFO head valid
- fetch_ready_i  in  1  decode accepts head
- fetch_rdata_o  out  32  head instruction word
- fetch_addr_o  out  32  head address
- fetch_err_o  out  1  head carries a bus error

Behaviour:
- Reset (async, rst_i=1): state IDLE; FIFO empty; outstanding=0; discard=0; req_addr=0; rsp_addr=0.
- Outputs under reset: instr_req_o=0, instr_addr_o=0, fetch_valid_o=0, fetch_rdata_o=0, fetch_addr_o=0, fetch_err_o=0.
- FSM states:
  - IDLE -> RUN on the first cycle with fetch_enable_i==FETCH_EN_ON. Loads req_addr and rsp_addr from {boot_addr_i[31:2],2'b00}.
  - RUN -> HALT_ERR when an error response is accepted (not discarded).
  - HALT_ERR -> RUN on branch_i.
  - A branch_i in IDLE is ignored.
- Issue rule: instr_req_o=1 when all of the following hold:
  - state is RUN;
  - fetch is enabled;
  - outstanding < MAX_OUTSTANDING;
  - fifo_count + outstanding < DEPTH.
  - The last condition guarantees every response has a FIFO slot; overflow is impossible (bench asserts it).
- Request/grant handling:
  - Once instr_req_o is high, it and instr_addr_o stay stable until instr_gnt_i, regardless of branch_i or enable drop.
  - On req&gnt: outstanding+1, req_addr+=4 (32-bit wrap from 0xFFFFFFFC to 0).
- Response handling on rvalid:
  - Always: outstanding-1.
  - If discard>0: discard-1 and drop the response.
  - Else: push {rdata, rsp_addr, err} and rsp_addr+=4.
  - Simultaneous gnt and rvalid: outstanding unchanged.
- Latency: rvalid in cycle N -> fetch_valid_o in cycle N+1. Earliest fetch after enable: req in the cycle after IDLE->RUN.
- Pop: fetch_valid_o & fetch_ready_i removes the head. Push and pop may occur in the same cycle, including when the FIFO is full.
- Branch (branch_i=1 in RUN/HALT_ERR):
  - FIFO cleared; pop that cycle ignored.
  - discard = outstanding_next, where outstanding_next counts a same-cycle grant and excludes a same-cycle rvalid. A same-cycle rvalid is dropped.
  - req_addr and rsp_addr := {branch_addr_i[31:2],2'b00}.
  - If a request is pending ungranted, it completes at its old address, is counted into discard when granted, and new-target fetching starts after it.
- Back-to-back branches: latest target wins; discard recomputed from the current outstanding count.
- fetch_enable_i deasserted in RUN: no new requests; outstanding responses still complete and are buffered; no flush.
- Error: fetch_err_o returned with its word (rdata as received). No further requests until a branch.

Decomposition:
- xmint_pkg:
  - localparam FETCH_EN_ON=4'b0101;
  - typedef fetch_entry_t {logic [31:0] rdata; logic [31:0] addr; logic err;};
  - enum pf_state_e {PF_IDLE, PF_RUN, PF_HALT_ERR}.
- Sub-module xmint_fifo:
  - generic synchronous FIFO, parameters DEPTH and entry type/width;
  - push/pop/flush, count, full/empty;
  - async active-high reset.

Test Plan:
- Enable with boot_addr_i=0x80, gnt=1, rvalid one cycle after each gnt, ready=1 -> addresses 0x80, 0x84, 0x88 issued; fetch_addr_o follows with 1-cycle latency after rvalid; never more than 2 outstanding.
- fetch_ready_i=0, DEPTH=4 -> exactly 4 requests granted, then instr_req_o=0. Raise ready -> fetching resumes, data in order, no loss.
- Two outstanding (0x100, 0x104), branch_i to 0x200 -> both responses dropped, fetch_valid_o stays 0 until data for 0x200 arrives.
- Req to 0x10 held with gnt=0, branch to 0x40 -> instr_addr_o stays 0x10 until gnt, its response is discarded, next request is 0x40.
- Response with instr_err_i=1 at 0x20 -> entry with fetch_err_o=1, fetch_addr_o=0x20; no requests until branch to 0x300, then fetching restarts at 0x300.
- rst_i pulsed mid-run with 2 outstanding -> all outputs 0 immediately; after release, fetch restarts from boot_addr_i once enabled.
